// File: rtl/regfile_mp_sb_if.sv
// Decode-stage register file bus: read ports, write ports, issue/reserve and stall.
// master = pipeline control side, slave = register file.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
);
  logic                       stall_flag;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       hazard;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;

  modport master (
    output stall_flag, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy, hazard
  );

  modport slave (
    input  stall_flag, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy, hazard
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port decode register file with per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic              clk,
  input logic              reset,
  regfile_mp_sb_if.slave   bus
);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      wr_clr;
  logic [NUM_REGS-1:0]      iss_set;
  logic [NUM_REGS-1:0]      busy_nxt;
  logic [ADDR_W-1:0]        wa   [NUM_WR];
  logic [DATA_W-1:0]        wd   [NUM_WR];
  logic [NUM_WR-1:0]        wok;
  logic [ADDR_W-1:0]        ra   [NUM_RD];
  logic [DATA_W-1:0]        rval [NUM_RD];
  logic [NUM_RD-1:0]        rbsy;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_q;
  logic                     hazard_c;

  // Unpack write ports, build write-clear and issue-set masks for the scoreboard.
  always_comb begin
    wr_clr  = '0;
    iss_set = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wa[p]  = bus.wr_addr[p*ADDR_W +: ADDR_W];
      wd[p]  = bus.wr_data[p*DATA_W +: DATA_W];
      wok[p] = bus.wr_en[p] && !((ZERO_REG != 0) && (wa[p] == '0));
      if (wok[p])
        wr_clr[wa[p]] = 1'b1;
    end
    if (bus.issue_en && !bus.stall_flag && !((ZERO_REG != 0) && (bus.issue_addr == '0)))
      iss_set[bus.issue_addr] = 1'b1;
    // A new producer supersedes the one completing this cycle.
    busy_nxt = (busy & ~wr_clr) | iss_set;
  end

  // Read-port lookup and hazard detection (forwarding variant under the macro).
  always_comb begin
    hazard_c = 1'b0;
    rbsy     = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i]   = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      rval[i] = regs[ra[i]];
      for (int unsigned p = 0; p < NUM_WR; p++)
        if (wok[p] && (wa[p] == ra[i]))
          rval[i] = wd[p];
      rbsy[i]  = busy_nxt[ra[i]];
      hazard_c = hazard_c | (busy[ra[i]] & ~wr_clr[ra[i]]);
`else
      rval[i]  = regs[ra[i]];
      rbsy[i]  = busy[ra[i]];
      hazard_c = hazard_c | busy[ra[i]];
`endif
      if ((ZERO_REG != 0) && (ra[i] == '0)) begin
        rval[i] = '0;
        rbsy[i] = 1'b0;
      end
    end
  end

  // Register array, scoreboard and registered read outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      busy      <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      // Ascending port order: the last assignment (highest index) wins on conflicts.
      for (int unsigned p = 0; p < NUM_WR; p++)
        if (wok[p])
          regs[wa[p]] <= wd[p];
      busy <= busy_nxt;
      if (!bus.stall_flag) begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
          rd_data_q[i*DATA_W +: DATA_W] <= rval[i];
          rd_busy_q[i]                  <= rbsy[i];
        end
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_busy = rd_busy_q;
  assign bus.hazard  = hazard_c;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default 32x32, 2R/2W, ZERO_REG=1).
module tb_regfile_mp_sb;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  regfile_mp_sb_if #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp_sb #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[0]        = 1'b1;
    bus.wr_addr[4:0]    = a;
    bus.wr_data[31:0]   = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[1]        = 1'b1;
    bus.wr_addr[9:5]    = a;
    bus.wr_data[63:32]  = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = a;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.issue_en = 1'b0;
  endtask

  logic [31:0] exp_byp;
  logic        exp_hz_wr;

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef REGFILE_BYPASS_EN
    exp_byp   = 32'h66;
    exp_hz_wr = 1'b0;
`else
    exp_byp   = 32'h0;
    exp_hz_wr = 1'b1;
`endif
    reset          = 1'b0;
    bus.stall_flag = 1'b0;
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;

    // Reset state
    #12;
    check("rst_rd_data", bus.rd_data, 64'h0);
    check("rst_rd_busy", bus.rd_busy, 64'h0);
    check("rst_hazard",  bus.hazard,  64'h0);
    reset = 1'b1;
    tick();

    // Write r5 then read it back
    wr0(5'd5, 32'h5);
    tick();
    idle();
    set_rd(5'd5, 5'd0);
    tick();
    check("rd5_data", bus.rd_data[31:0], 64'h5);
    check("rd5_busy", bus.rd_busy[0],    64'h0);

    // Same-address write conflict: port 1 wins
    wr0(5'd3, 32'hAAAA);
    wr1(5'd3, 32'h5555);
    tick();
    idle();
    set_rd(5'd3, 5'd0);
    tick();
    check("conflict_r3", bus.rd_data[31:0], 64'h5555);

    // Issue r7 -> hazard on read port 1
    issue(5'd7);
    tick();
    idle();
    set_rd(5'd3, 5'd7);
    #1;
    check("issue7_hazard", bus.hazard, 64'h1);
    tick();
    check("issue7_rd_busy", bus.rd_busy[1], 64'h1);

    // Writeback r7=9 clears busy
    wr1(5'd7, 32'h9);
    #1;
    check("wr7_hazard_same_cycle", bus.hazard, {63'h0, exp_hz_wr});
    tick();
    idle();
    #1;
    check("wr7_hazard_after", bus.hazard, 64'h0);
    tick();
    check("wr7_rd_data1", bus.rd_data[63:32], 64'h9);
    check("wr7_rd_busy1", bus.rd_busy[1],     64'h0);

    // Issue and write r7 in the same cycle: busy stays set
    issue(5'd7);
    wr0(5'd7, 32'hA);
    tick();
    idle();
    #1;
    check("set_wins_hazard", bus.hazard, 64'h1);
    wr0(5'd7, 32'h9);
    tick();
    idle();
    #1;
    check("r7_released", bus.hazard, 64'h0);

    // Stall holds read outputs and blocks issue, not writes
    wr0(5'd4, 32'h4);
    tick();
    idle();
    set_rd(5'd4, 5'd0);
    tick();
    check("stall_pre_r4", bus.rd_data[31:0], 64'h4);
    bus.stall_flag = 1'b1;
    wr0(5'd4, 32'h2C);
    issue(5'd12);
    set_rd(5'd5, 5'd0);
    tick();
    idle();
    tick();
    check("stall_hold_r4", bus.rd_data[31:0], 64'h4);
    set_rd(5'd5, 5'd12);
    #1;
    check("stall_no_issue", bus.hazard, 64'h0);
    bus.stall_flag = 1'b0;
    set_rd(5'd4, 5'd12);
    tick();
    check("unstall_r4",      bus.rd_data[31:0], 64'h2C);
    check("unstall_busy12",  bus.rd_busy[1],    64'h0);

    // Zero register
    wr0(5'd0, 32'hFFFF);
    issue(5'd0);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    #1;
    check("r0_hazard", bus.hazard, 64'h0);
    tick();
    check("r0_data", bus.rd_data, 64'h0);
    check("r0_busy", bus.rd_busy, 64'h0);

    // Same-cycle write/read of r6
    set_rd(5'd6, 5'd5);
    wr0(5'd6, 32'h66);
    tick();
    idle();
    check("bypass_r6", bus.rd_data[31:0], {32'h0, exp_byp});
    tick();
    check("r6_after", bus.rd_data[31:0], 64'h66);

    // Reset mid-operation
    issue(5'd2);
    tick();
    idle();
    set_rd(5'd2, 5'd5);
    #1;
    check("r2_hazard", bus.hazard, 64'h1);
    tick();
    check("r2_rd_busy", bus.rd_busy[0],     64'h1);
    check("r5_pre_rst", bus.rd_data[63:32], 64'h5);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_data",   bus.rd_data, 64'h0);
    check("midrst_busy",   bus.rd_busy, 64'h0);
    check("midrst_hazard", bus.hazard,  64'h0);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_r5", bus.rd_data[63:32], 64'h0);
    check("post_rst_r2", bus.rd_busy[0],     64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
